// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer and the datapath PC mux.
package hazard_pkg;

  localparam int unsigned REG_W = 5;

  // PC mux source select
  typedef enum logic [2:0] {
    PC4    = 3'd0,
    BRANCH = 3'd1,
    JUMP   = 3'd2,
    JR     = 3'd3,
    IRQ    = 3'd4,
    EXC    = 3'd5
  } pc_sel_e;

  // Sequencer states
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    IRQ_WAIT = 2'd2
  } state_e;

  // Trap vectors consumed by the datapath PC mux
  localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between a load in EX and the source registers read in ID.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  output logic             load_use_c
);

  // A load to $0 never creates a dependency
  assign load_use_c = ex_memread
                    & ((id_uses_rs & (ex_rt == id_rs)) | (id_uses_rt & (ex_rt == id_rt)))
                    & (ex_rt != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline sequencer: one prioritised stall/flush/redirect decision per cycle.
// BUSY_TIMEOUT is expected to be at least 2.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned BUSY_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_kernel,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             id_jr,
  input  logic             id_undef,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  input  logic             irq_in,
  output logic             pc_we,
  output logic [2:0]       pc_sel,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exme_we,
  output logic             memwb_bubble,
  output logic             epc_we,
  output logic             epc_src,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned BUSY_W = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [1:0] S_RUN      = RUN;
  localparam logic [1:0] S_MEM_WAIT = MEM_WAIT;
  localparam logic [1:0] S_IRQ_WAIT = IRQ_WAIT;

  logic [1:0]        state_q, state_d;
  logic              irq_pend_q, irq_pend_d;
  logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
  logic              bus_err_d;
  logic [CNT_W-1:0]  stall_cnt_d;
  logic              load_use;
  logic              take_irq;
  logic              timeout;

  hazard_detect u_hazard_detect (
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .load_use_c (load_use)
  );

  // State, pending IRQ, busy timer, sticky bus error and stall counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_RUN;
      irq_pend_q <= 1'b0;
      busy_cnt_q <= '0;
      bus_err    <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      state_q    <= state_d;
      irq_pend_q <= irq_pend_d;
      busy_cnt_q <= busy_cnt_d;
      bus_err    <= bus_err_d;
      stall_cnt  <= stall_cnt_d;
    end
  end

  // Prioritised per-cycle decision and next-state logic
  always_comb begin
    pc_we        = 1'b1;
    pc_sel       = PC4;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exme_we      = 1'b1;
    memwb_bubble = 1'b0;
    epc_we       = 1'b0;
    epc_src      = 1'b0;
    take_irq     = 1'b0;
    timeout      = 1'b0;
    state_d      = S_RUN;
    busy_cnt_d   = '0;
    bus_err_d    = bus_err;

    if (mem_busy) begin
      if ((state_q == S_MEM_WAIT) && (busy_cnt_q == BUSY_W'(BUSY_TIMEOUT - 1))) begin
        // Abandon the stuck access: trap and let EX/MEM advance past it
        timeout      = 1'b1;
        bus_err_d    = 1'b1;
        pc_sel       = EXC;
        epc_we       = 1'b1;
        epc_src      = 1'b1;
        ifid_flush   = 1'b1;
        idex_bubble  = 1'b1;
        memwb_bubble = 1'b1;
      end else begin
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        exme_we      = 1'b0;
        memwb_bubble = 1'b1;
        state_d      = S_MEM_WAIT;
        busy_cnt_d   = busy_cnt_q + BUSY_W'(1);
      end
    end else if (ex_branch_taken) begin
      pc_sel      = BRANCH;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (id_valid && id_undef) begin
      pc_sel      = EXC;
      epc_we      = 1'b1;
      epc_src     = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (irq_pend_q && id_valid && !id_kernel) begin
      take_irq    = 1'b1;
      pc_sel      = IRQ;
      epc_we      = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end else if (id_jump) begin
      pc_sel     = JUMP;
      ifid_flush = 1'b1;
    end else if (id_jr) begin
      pc_sel     = JR;
      ifid_flush = 1'b1;
    end

    // Level-sensitive request: tracks irq_in, dropped once accepted
    irq_pend_d = irq_in && !take_irq;

    if (!mem_busy && irq_pend_q && irq_pend_d) begin
      state_d = S_IRQ_WAIT;
    end

    // Outputs show their reset values while reset is held
    if (reset) begin
      pc_we        = 1'b0;
      pc_sel       = PC4;
      ifid_we      = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exme_we      = 1'b0;
      memwb_bubble = 1'b1;
      epc_we       = 1'b0;
      epc_src      = 1'b0;
    end

    stall_cnt_d = stall_cnt;
    if (!pc_we && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: expected decisions queued at drive time, compared mid-cycle.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W        = 8;
  localparam int unsigned BUSY_TIMEOUT = 16;

  logic             clk;
  logic             reset;
  logic             id_valid, id_kernel;
  logic [4:0]       id_rs, id_rt;
  logic             id_uses_rs, id_uses_rt, id_jump, id_jr, id_undef;
  logic             ex_memread;
  logic [4:0]       ex_rt;
  logic             ex_branch_taken, mem_busy, irq_in;
  logic             pc_we;
  logic [2:0]       pc_sel;
  logic             ifid_we, ifid_flush, idex_bubble, exme_we, memwb_bubble;
  logic             epc_we, epc_src, bus_err;
  logic [CNT_W-1:0] stall_cnt;

  pipeline_hazard_ctrl #(.BUSY_TIMEOUT(BUSY_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_kernel       (id_kernel),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_jump         (id_jump),
    .id_jr           (id_jr),
    .id_undef        (id_undef),
    .ex_memread      (ex_memread),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .irq_in          (irq_in),
    .pc_we           (pc_we),
    .pc_sel          (pc_sel),
    .ifid_we         (ifid_we),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .exme_we         (exme_we),
    .memwb_bubble    (memwb_bubble),
    .epc_we          (epc_we),
    .epc_src         (epc_src),
    .bus_err         (bus_err),
    .stall_cnt       (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decision kinds the stimulus expects the sequencer to take
  typedef enum int {K_NORM, K_FREEZE, K_TIMEOUT, K_BRANCH, K_EXC, K_IRQ, K_LU, K_JUMP, K_JR} kind_e;

  typedef struct {
    string            tag;
    logic [10:0]      dec;
    logic [CNT_W-1:0] stall;
    logic             berr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [CNT_W-1:0] m_stall;
  logic             m_berr;

  // {pc_we, pc_sel, ifid_we, ifid_flush, idex_bubble, exme_we, memwb_bubble, epc_we, epc_src}
  logic [10:0] dec_obs;
  assign dec_obs = {pc_we, pc_sel, ifid_we, ifid_flush, idex_bubble, exme_we, memwb_bubble, epc_we, epc_src};

  localparam logic [10:0] RESET_DEC = {1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  function automatic logic [10:0] exp_dec(input kind_e k);
    case (k)
      K_FREEZE:  return {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      K_TIMEOUT: return {1'b1, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      K_BRANCH:  return {1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      K_EXC:     return {1'b1, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      K_IRQ:     return {1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      K_LU:      return {1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      K_JUMP:    return {1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      K_JR:      return {1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      default:   return {1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    id_valid = 1'b1; id_kernel = 1'b0; id_rs = 5'd0; id_rt = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_jump = 1'b0; id_jr = 1'b0; id_undef = 1'b0;
    ex_memread = 1'b0; ex_rt = 5'd0; ex_branch_taken = 1'b0; mem_busy = 1'b0; irq_in = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "/dec"},   32'(dec_obs),   32'(RESET_DEC));
    chk({tag, "/stall"}, 32'(stall_cnt), 32'd0);
    chk({tag, "/berr"},  32'(bus_err),   32'd0);
  endtask

  // Queue the expected outcome for the cycle just driven, then advance the bench model past the edge
  task automatic cycle(input kind_e k, input string tag);
    exp_t e;
    e.tag   = tag;
    e.dec   = exp_dec(k);
    e.stall = m_stall;
    e.berr  = m_berr;
    sb_q.push_back(e);
    @(posedge clk);
    if ((k == K_FREEZE || k == K_LU) && (m_stall != {CNT_W{1'b1}})) m_stall = m_stall + CNT_W'(1);
    if (k == K_TIMEOUT) m_berr = 1'b1;
    #1;
  endtask

  // Compare DUT outputs against the oldest queued expectation, half a cycle after driving
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({e.tag, "/dec"},   32'(dec_obs),   32'(e.dec));
      chk({e.tag, "/stall"}, 32'(stall_cnt), 32'(e.stall));
      chk({e.tag, "/berr"},  32'(bus_err),   32'(e.berr));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [CNT_W-1:0] s0;
    reset = 1'b1;
    set_idle();
    m_stall = '0;
    m_berr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst_init");
    reset = 1'b0;
    cycle(K_NORM, "first_run");

    // Load-use: lw $8 in EX, add $9,$8,$1 in ID
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_rt = 5'd1; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
    cycle(K_LU, "lu_rs");
    ex_memread = 1'b0;
    cycle(K_NORM, "lu_after");
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    cycle(K_NORM, "lu_r0");
    ex_rt = 5'd8; id_rs = 5'd3; id_rt = 5'd8;
    cycle(K_LU, "lu_rt");
    id_uses_rt = 1'b0;
    cycle(K_NORM, "lu_rt_unused");

    // Branch beats jump and load-use; then jump, jr, undefined
    id_uses_rt = 1'b1; ex_branch_taken = 1'b1; id_jump = 1'b1;
    cycle(K_BRANCH, "br_over_jump");
    set_idle(); id_jump = 1'b1;
    cycle(K_JUMP, "jump");
    id_jump = 1'b0; id_jr = 1'b1;
    cycle(K_JR, "jr");
    set_idle(); id_undef = 1'b1;
    cycle(K_EXC, "undef");
    id_valid = 1'b0;
    cycle(K_NORM, "undef_bubble");

    // IRQ arriving with a taken branch waits for a valid instruction
    set_idle(); irq_in = 1'b1; ex_branch_taken = 1'b1;
    cycle(K_BRANCH, "irq_br");
    ex_branch_taken = 1'b0; id_valid = 1'b0;
    cycle(K_NORM, "irq_bubble");
    id_valid = 1'b1;
    cycle(K_IRQ, "irq_take");
    irq_in = 1'b0; id_valid = 1'b0;
    cycle(K_NORM, "irq_flushed");
    id_valid = 1'b1;
    cycle(K_NORM, "irq_cleared");

    // IRQ masked in kernel mode, taken on first user instruction only
    id_kernel = 1'b1; irq_in = 1'b1;
    for (int i = 0; i < 5; i++) cycle(K_NORM, "irq_kernel");
    id_kernel = 1'b0;
    cycle(K_IRQ, "irq_user");
    id_kernel = 1'b1;
    cycle(K_NORM, "irq_kernel_after");
    cycle(K_NORM, "irq_kernel_after");
    irq_in = 1'b0;
    cycle(K_NORM, "irq_drop");
    id_kernel = 1'b0;
    cycle(K_NORM, "irq_dropped");

    // Undefined instruction outranks a pending IRQ, which is kept
    irq_in = 1'b1; id_kernel = 1'b1;
    cycle(K_NORM, "irq_arm");
    id_kernel = 1'b0; id_undef = 1'b1;
    cycle(K_EXC, "exc_over_irq");
    id_undef = 1'b0;
    cycle(K_IRQ, "irq_after_exc");
    irq_in = 1'b0; id_kernel = 1'b1;
    cycle(K_NORM, "irq_done");
    set_idle();

    // Short peripheral wait
    s0 = m_stall;
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) cycle(K_FREEZE, "mem3");
    mem_busy = 1'b0;
    cycle(K_NORM, "mem3_release");
    chk("mem3_stall_delta", 32'(stall_cnt), 32'(s0) + 32'd3);

    // Leaving MEM_WAIT applies the RUN priorities in the same cycle
    mem_busy = 1'b1;
    for (int i = 0; i < 2; i++) cycle(K_FREEZE, "mem2");
    mem_busy = 1'b0; ex_branch_taken = 1'b1;
    cycle(K_BRANCH, "mem_exit_branch");
    set_idle();

    // Busy timeout on the 16th consecutive busy cycle
    mem_busy = 1'b1;
    for (int i = 0; i < 15; i++) cycle(K_FREEZE, "mem16");
    cycle(K_TIMEOUT, "mem_timeout");
    mem_busy = 1'b0;
    cycle(K_NORM, "after_timeout");
    chk("bus_err_sticky", 32'(bus_err), 32'd1);

    // 15 busy cycles stay below the timeout
    mem_busy = 1'b1;
    for (int i = 0; i < 15; i++) cycle(K_FREEZE, "mem15");
    mem_busy = 1'b0;
    cycle(K_NORM, "mem15_no_timeout");

    // Async reset in the middle of a freeze
    mem_busy = 1'b1;
    for (int i = 0; i < 2; i++) cycle(K_FREEZE, "mem_pre_rst");
    reset = 1'b1;
    #1;
    check_reset("rst_mid");
    m_stall = '0;
    m_berr  = 1'b0;
    @(posedge clk);
    #1;
    check_reset("rst_hold");
    mem_busy = 1'b0;
    reset = 1'b0;
    cycle(K_NORM, "post_rst");

    // Stall counter saturation
    ex_memread = 1'b1; ex_rt = 5'd7; id_rs = 5'd7; id_uses_rs = 1'b1;
    for (int i = 0; i < 260; i++) cycle(K_LU, "sat");
    set_idle();
    cycle(K_NORM, "sat_hold");
    chk("stall_saturated", 32'(stall_cnt), 32'd255);

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage CPU pipeline. It owns every PC-write, IF/ID-write, flush and bubble decision. It merges load-use stalls, EX-stage branch redirects, ID-stage jumps, undefined-instruction exceptions, external IRQ entry and multi-cycle peripheral waits into one prioritised decision per cycle. It sits beside the datapath: it takes decoded hazard inputs from ID, EX and MEM and drives the pipeline-register enables and the PC mux select.

Parameters:
BUSY_TIMEOUT, 16, max consecutive mem_busy cycles before a bus-error exception
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  clock
reset  in  1  async reset
id_valid  in  1  ID holds a real instruction (not a flush bubble)
id_kernel  in  1  IF/ID PC[31]; kernel mode, IRQ masked
id_rs  in  5  ID rs field
id_rt  in  5  ID rt field
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_jump  in  1  ID is j/jal
id_jr  in  1  ID is jr/jalr
id_undef  in  1  ID opcode/funct undefined
ex_memread  in  1  EX instruction is a load
ex_rt  in  5  EX load destination
ex_branch_taken  in  1  EX branch resolved taken
mem_busy  in  1  MEM-stage peripheral access not complete
irq_in  in  1  peripheral interrupt request, level
pc_we  out  1  PC register write enable
pc_sel  out  3  PC source, pc_sel_e from package
ifid_we  out  1  IF/ID write enable
ifid_flush  out  1  IF/ID load bubble
idex_bubble  out  1  ID/EX control bits zeroed
exme_we  out  1  EX/MEM write enable
memwb_bubble  out  1  MEM/WB RegWrite forced 0
epc_we  out  1  datapath captures EPC (1 cycle)
epc_src  out  1  0: ID PC (IRQ, re-execute); 1: ID PC+4 (exception)
bus_err  out  1  sticky; set on busy timeout
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset values: state=RUN, pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, exme_we=0, memwb_bubble=1, epc_we=0, epc_src=0, bus_err=0, stall_cnt=0, irq_pend=0, busy_cnt=0.
- Decision outputs are combinational from state plus inputs. state, irq_pend, busy_cnt, bus_err and stall_cnt are registered.
- load_use = ex_memread & ((id_uses_rs & ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)) & ex_rt!=0.
- irq_pend: set when irq_in=1 is sampled; cleared on the cycle epc_we=1 with epc_src=0.
- States:
  - RUN: normal operation.
  - MEM_WAIT: entered when mem_busy=1.
  - IRQ_WAIT: IRQ pending but ID invalid or branch just taken.
- Priority per cycle in RUN (first match wins):
  1. mem_busy: whole pipe frozen (pc_we=ifid_we=exme_we=0, memwb_bubble=1, idex holds). Go to MEM_WAIT. busy_cnt++.
  2. ex_branch_taken: pc_sel=BRANCH, ifid_flush=1, idex_bubble=1. If irq_pend, go to IRQ_WAIT.
  3. id_valid & id_undef: pc_sel=EXC, epc_we=1, epc_src=1, ifid_flush=1, idex_bubble=1.
  4. irq_pend & id_valid & ~id_kernel: pc_sel=IRQ, epc_we=1, epc_src=0, ifid_flush=1, idex_bubble=1.
  5. load_use: pc_we=0, ifid_we=0, idex_bubble=1.
  6. id_jump / id_jr: pc_sel=JUMP / JR, ifid_flush=1.
  7. Otherwise: pc_sel=PC4, all enables 1.
- MEM_WAIT:
  - Hold the full freeze while mem_busy=1.
  - When mem_busy falls, return to RUN in the same cycle and apply the RUN rules to that cycle.
  - If busy_cnt reaches BUSY_TIMEOUT: bus_err=1, pc_sel=EXC, epc_we=1, epc_src=1, flush IF/ID and ID/EX, force exme_we=1 to drop the access, then RUN. busy_cnt clears on leaving MEM_WAIT.
- IRQ_WAIT:
  - Behaves like RUN, but takes the IRQ on the first cycle with id_valid & ~id_kernel and no higher-priority event.
  - Returns to RUN when the IRQ is taken, or when irq_pend is cleared by irq_in dropping before acceptance. The IRQ is level-based and not lost.
- The IRQ is never taken in kernel mode. An irq_in held high throughout kernel mode is taken on the first valid user instruction.
- stall_cnt increments on every cycle with pc_we=0 after reset release and saturates at all-ones.
- Reset mid-freeze: async; every register returns to its reset value immediately. The first post-reset cycle is RUN.

Decomposition:
- Package hazard_pkg:
  - pc_sel_e: PC4=0, BRANCH=1, JUMP=2, JR=3, IRQ=4, EXC=5.
  - state_e: RUN, MEM_WAIT, IRQ_WAIT.
  - IRQ_VECTOR=32'h80000004 and EXC_VECTOR=32'h80000008, for the datapath PC mux.
- One sub-module, hazard_detect: purely combinational load_use compare, reusable by the forwarding unit.

Test Plan:
- Load to $8, then add $9,$8,$1 -> exactly 1 cycle with pc_we=0, ifid_we=0, idex_bubble=1; stall_cnt=1. With ex_rt=0 -> no stall.
- ex_branch_taken=1 together with id_jump=1 -> pc_sel=1, ifid_flush=1, idex_bubble=1; jump ignored.
- irq_in=1 while ex_branch_taken=1 -> no epc_we that cycle. Next cycle, with id_valid=0 (the flush bubble), still no epc_we. First id_valid=1 cycle -> pc_sel=4, epc_we=1, epc_src=0, irq_pend clears.
- irq_in=1 with id_kernel=1 for 5 cycles, then id_kernel=0 -> epc_we fires on the first user cycle only.
- mem_busy=1 for 3 cycles -> pc_we=exme_we=0 for 3 cycles, stall_cnt+=3. mem_busy=1 for 16 cycles -> bus_err=1, pc_sel=5, epc_src=1.
- reset asserted mid-MEM_WAIT -> outputs at reset values the same cycle; after release, state=RUN and pc_sel=0 on the first enabled cycle.
